// File: rtl/mac_pkg.sv
// Shared types for the MAC operand sequencer: FSM state encoding and the
// buffered operand pair.
package mac_pkg;

  localparam int MAC_OPW  = 8;
  localparam int MAC_ACCW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_REPORT
  } seq_state_t;

  typedef struct packed {
    logic                      last;
    logic signed [MAC_OPW-1:0] a;
    logic signed [MAC_OPW-1:0] b;
  } mac_pair_t;

endpackage

// File: rtl/mac_operand_sequencer_fifo.sv
// Synchronous FIFO of operand pairs. Pointers carry an extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module mac_operand_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  mac_pair_t wdata,
  input  logic      pop,
  output mac_pair_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  mac_pair_t      mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries data only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Feeds buffered signed operand pairs to a handshake MAC one at a time,
// groups them into 'last'-delimited vectors and reports one result per vector.
module mac_operand_sequencer
  import mac_pkg::*;
#(
  parameter int OPW     = MAC_OPW,
  parameter int ACCW    = MAC_ACCW,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [OPW-1:0]  in_a,
  input  logic signed [OPW-1:0]  in_b,
  input  logic                   in_last,
  output logic                   mac_valid,
  output logic signed [OPW-1:0]  mac_a,
  output logic signed [OPW-1:0]  mac_b,
  output logic                   mac_clear,
  input  logic                   mac_done,
  input  logic                   mac_overflow,
  input  logic signed [ACCW-1:0] mac_y,
  output logic                   vec_valid,
  output logic signed [ACCW-1:0] vec_result,
  output logic                   vec_overflow,
  output logic                   vec_timeout,
  output logic [CNT_W-1:0]       vec_count,
  output logic                   busy
);

  localparam int                TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  seq_state_t              state;
  seq_state_t              next_state;
  mac_pair_t               head;
  mac_pair_t               pair_in;
  logic                    full;
  logic                    empty;
  logic                    pop;
  logic                    new_vec;
  logic                    last_q;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [CNT_W-1:0]        cnt_q;
  logic                    ovf_sticky;
  logic                    tmo_sticky;
  logic signed [ACCW-1:0]  acc_cap;
  logic signed [ACCW-1:0]  res_hold;
  logic                    ovf_hold;
  logic                    tmo_hold;
  logic [CNT_W-1:0]        cnt_hold;

  assign pair_in  = '{last: in_last, a: in_a, b: in_b};
  assign in_ready = !full;
  assign busy     = (state != S_IDLE) || !empty;

  mac_operand_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid && !full),
    .wdata (pair_in),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    next_state = state;
    mac_valid  = 1'b0;
    mac_clear  = 1'b0;
    vec_valid  = 1'b0;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) next_state = new_vec ? S_CLEAR : S_ISSUE;
      end
      S_CLEAR: begin
        mac_clear  = 1'b1;
        next_state = S_ISSUE;
      end
      S_ISSUE: begin
        mac_valid  = 1'b1;
        pop        = 1'b1;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the final timeout cycle still counts as success.
        if (mac_done) begin
          if (mac_overflow && !last_q) next_state = S_DRAIN;
          else if (last_q)             next_state = S_REPORT;
          else                         next_state = S_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          next_state = last_q ? S_REPORT : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.last) next_state = S_REPORT;
        end
      end
      S_REPORT: begin
        vec_valid  = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Report fields are live during S_REPORT and held between reports.
  always_comb begin
    if (state == S_REPORT) begin
      vec_result   = acc_cap;
      vec_overflow = ovf_sticky;
      vec_timeout  = tmo_sticky;
      vec_count    = cnt_q;
    end else begin
      vec_result   = res_hold;
      vec_overflow = ovf_hold;
      vec_timeout  = tmo_hold;
      vec_count    = cnt_hold;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      new_vec    <= 1'b1;
      last_q     <= 1'b0;
      tmo_cnt    <= '0;
      cnt_q      <= '0;
      ovf_sticky <= 1'b0;
      tmo_sticky <= 1'b0;
      mac_a      <= '0;
      mac_b      <= '0;
      res_hold   <= '0;
      ovf_hold   <= 1'b0;
      tmo_hold   <= 1'b0;
      cnt_hold   <= '0;
    end else begin
      state <= next_state;
      // Operands are presented together with the mac_valid pulse.
      if (next_state == S_ISSUE) begin
        mac_a <= head.a;
        mac_b <= head.b;
      end
      case (state)
        S_CLEAR: begin
          new_vec    <= 1'b0;
          cnt_q      <= '0;
          ovf_sticky <= 1'b0;
          tmo_sticky <= 1'b0;
        end
        S_ISSUE: begin
          last_q  <= head.last;
          cnt_q   <= sat_inc(cnt_q);
          tmo_cnt <= '0;
        end
        S_WAIT: begin
          if (mac_done) begin
            if (mac_overflow) ovf_sticky <= 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_sticky <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_REPORT: begin
          new_vec  <= 1'b1;
          res_hold <= acc_cap;
          ovf_hold <= ovf_sticky;
          tmo_hold <= tmo_sticky;
          cnt_hold <= cnt_q;
        end
        default: ;
      endcase
    end
  end

  // Captured accumulator is data: cleared per vector, not by reset.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR)                acc_cap <= '0;
    else if (state == S_WAIT && mac_done) acc_cap <= mac_y;
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench: a behavioural MAC (accumulate a*b, done one cycle after
// valid, stallable) drives the sequencer; vector results come from a table.
module tb_mac_operand_sequencer;

  localparam int OPW     = 8;
  localparam int ACCW    = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [OPW-1:0]  in_a;
  logic signed [OPW-1:0]  in_b;
  logic                   in_last;
  logic                   mac_valid;
  logic signed [OPW-1:0]  mac_a;
  logic signed [OPW-1:0]  mac_b;
  logic                   mac_clear;
  logic                   mac_done;
  logic                   mac_overflow;
  logic signed [ACCW-1:0] mac_y;
  logic                   vec_valid;
  logic signed [ACCW-1:0] vec_result;
  logic                   vec_overflow;
  logic                   vec_timeout;
  logic [CNT_W-1:0]       vec_count;
  logic                   busy;

  always #5 clk = ~clk;

  mac_operand_sequencer #(
    .OPW(OPW), .ACCW(ACCW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b), .mac_clear(mac_clear),
    .mac_done(mac_done), .mac_overflow(mac_overflow), .mac_y(mac_y),
    .vec_valid(vec_valid), .vec_result(vec_result), .vec_overflow(vec_overflow),
    .vec_timeout(vec_timeout), .vec_count(vec_count), .busy(busy)
  );

  // Behavioural MAC: wrapping accumulator, sticky overflow, stallable done.
  logic signed [ACCW-1:0] acc;
  logic                   ovf;
  logic                   pend;
  logic                   stall;
  int                     sum;

  always_comb sum = int'(acc) + int'(mac_a) * int'(mac_b);
  assign mac_y        = acc;
  assign mac_overflow = ovf;
  assign mac_done     = pend && !stall;

  always @(posedge clk) begin
    if (reset || mac_clear) begin
      acc  <= '0;
      ovf  <= 1'b0;
      pend <= 1'b0;
    end else if (mac_valid) begin
      acc  <= sum[ACCW-1:0];
      if (sum > 32767 || sum < -32768) ovf <= 1'b1;
      pend <= 1'b1;
    end else if (mac_done) begin
      pend <= 1'b0;
    end
  end

  // Monitor
  typedef struct {
    int res;
    int ovf;
    int tmo;
    int cnt;
  } rep_t;

  int   iss_a[$];
  int   iss_b[$];
  rep_t rep_q[$];
  int   n_clear = 0;
  int   cycle   = 0;
  int   t_valid = 0;
  int   t_rep   = 0;

  always @(negedge clk) begin
    cycle <= cycle + 1;
    if (mac_valid) begin
      iss_a.push_back(int'(mac_a));
      iss_b.push_back(int'(mac_b));
      t_valid <= cycle;
    end
    if (mac_clear) n_clear <= n_clear + 1;
    if (vec_valid) begin
      rep_q.push_back('{int'(vec_result), int'(vec_overflow), int'(vec_timeout), int'(vec_count)});
      t_rep <= cycle;
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_pair(input int a, input int b, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_a     = OPW'(a);
    in_b     = OPW'(b);
    in_last  = last;
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check("push_ready_wait", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_reports(input int target, input int max_cycles, input string name);
    int i;
    i = 0;
    while (rep_q.size() < target && i < max_cycles) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    check(name, rep_q.size(), target);
  endtask

  typedef struct {
    int n;
    int a[4];
    int b[4];
    int res;
    int cnt;
    int ovf;
    int iss;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int rb;
    int ib;
    int cb;
    int guard;

    tbl[0] = '{2, '{30, 10, 0, 0},        '{40, 8, 0, 0},         1280,  2, 0, 2};
    tbl[1] = '{4, '{-127, -127, -127, -127}, '{127, 127, 127, 127}, 17149, 3, 1, 3};
    tbl[2] = '{1, '{-128, 0, 0, 0},       '{-128, 0, 0, 0},       16384, 1, 0, 1};
    tbl[3] = '{4, '{127, -1, 0, 2},       '{127, 1, 5, 3},        16134, 4, 0, 4};
    tbl[4] = '{3, '{5, -3, 100, 0},       '{-7, -9, 100, 0},      9992,  3, 0, 3};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_last  = 1'b0;
    stall    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_in_ready",  int'(in_ready), 1);
    check("rst_mac_valid", int'(mac_valid), 0);
    check("rst_vec_valid", int'(vec_valid), 0);
    check("rst_busy",      int'(busy), 0);
    check("rst_vec_count", int'(vec_count), 0);

    // Table-driven vectors
    for (int r = 0; r < 5; r++) begin
      rb = rep_q.size();
      ib = iss_a.size();
      cb = n_clear;
      for (int k = 0; k < tbl[r].n; k++)
        push_pair(tbl[r].a[k], tbl[r].b[k], k == tbl[r].n - 1);
      wait_reports(rb + 1, 400, $sformatf("row%0d_nrep", r));
      if (rep_q.size() > rb) begin
        check($sformatf("row%0d_result", r), rep_q[rb].res, tbl[r].res);
        check($sformatf("row%0d_count", r),  rep_q[rb].cnt, tbl[r].cnt);
        check($sformatf("row%0d_ovf", r),    rep_q[rb].ovf, tbl[r].ovf);
        check($sformatf("row%0d_tmo", r),    rep_q[rb].tmo, 0);
      end
      check($sformatf("row%0d_clears", r), n_clear - cb, 1);
      check($sformatf("row%0d_issued", r), iss_a.size() - ib, tbl[r].iss);
      for (int k = 0; k < tbl[r].iss && ib + k < iss_a.size(); k++) begin
        check($sformatf("row%0d_a%0d", r, k), iss_a[ib + k], tbl[r].a[k]);
        check($sformatf("row%0d_b%0d", r, k), iss_b[ib + k], tbl[r].b[k]);
      end
      check($sformatf("row%0d_busy", r), int'(busy), 0);
    end

    // Backpressure: MAC stalled, five pairs fill the four-entry FIFO
    rb    = rep_q.size();
    ib    = iss_a.size();
    stall = 1'b1;
    for (int k = 0; k < 5; k++) push_pair(2 * k + 1, 2 * k + 2, k == 4);
    check("bp_in_ready_full", int'(in_ready), 0);
    check("bp_issued_stalled", iss_a.size() - ib, 1);
    stall = 1'b0;
    wait_reports(rb + 1, 400, "bp_nrep");
    if (rep_q.size() > rb) begin
      check("bp_result", rep_q[rb].res, 190);
      check("bp_count",  rep_q[rb].cnt, 5);
    end
    check("bp_issued", iss_a.size() - ib, 5);
    for (int k = 0; k < 5 && ib + k < iss_a.size(); k++) begin
      check($sformatf("bp_a%0d", k), iss_a[ib + k], 2 * k + 1);
      check($sformatf("bp_b%0d", k), iss_b[ib + k], 2 * k + 2);
    end

    // Timeout on a single-pair vector: report exactly TIMEOUT cycles into S_WAIT
    rb    = rep_q.size();
    stall = 1'b1;
    push_pair(3, 3, 1'b1);
    wait_reports(rb + 1, 200, "tmo_nrep");
    if (rep_q.size() > rb) begin
      check("tmo_flag",   rep_q[rb].tmo, 1);
      check("tmo_count",  rep_q[rb].cnt, 1);
      check("tmo_ovf",    rep_q[rb].ovf, 0);
      check("tmo_result", rep_q[rb].res, 0);
    end
    check("tmo_latency", t_rep - t_valid, TIMEOUT + 1);

    // Timeout mid-vector: remaining pairs are drained, not issued
    rb = rep_q.size();
    ib = iss_a.size();
    push_pair(1, 1, 1'b0);
    push_pair(2, 2, 1'b0);
    push_pair(3, 3, 1'b1);
    wait_reports(rb + 1, 200, "tmod_nrep");
    if (rep_q.size() > rb) begin
      check("tmod_flag",  rep_q[rb].tmo, 1);
      check("tmod_count", rep_q[rb].cnt, 1);
    end
    check("tmod_issued", iss_a.size() - ib, 1);
    check("tmod_busy", int'(busy), 0);
    stall = 1'b0;
    repeat (3) @(negedge clk);

    // Back-to-back single-pair vectors
    rb = rep_q.size();
    cb = n_clear;
    push_pair(100, -2, 1'b1);
    push_pair(11, -11, 1'b1);
    wait_reports(rb + 2, 300, "b2b_nrep");
    if (rep_q.size() > rb + 1) begin
      check("b2b_result0", rep_q[rb].res, -200);
      check("b2b_result1", rep_q[rb + 1].res, -121);
      check("b2b_count1",  rep_q[rb + 1].cnt, 1);
    end
    check("b2b_clears", n_clear - cb, 2);

    // Reset while waiting on the MAC: partial vector dropped, no report
    rb    = rep_q.size();
    ib    = iss_a.size();
    stall = 1'b1;
    push_pair(4, 4, 1'b0);
    push_pair(5, 5, 1'b0);
    guard = 0;
    while (iss_a.size() == ib && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("rw_issue_seen", iss_a.size() - ib, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rw_in_ready",   int'(in_ready), 1);
    check("rw_mac_valid",  int'(mac_valid), 0);
    check("rw_mac_a",      int'(mac_a), 0);
    check("rw_vec_result", int'(vec_result), 0);
    check("rw_vec_count",  int'(vec_count), 0);
    check("rw_busy",       int'(busy), 0);
    reset = 1'b0;
    stall = 1'b0;
    repeat (100) @(negedge clk);
    check("rw_no_report", rep_q.size() - rb, 0);
    check("rw_no_reissue", iss_a.size() - ib, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
